// File: rtl/photon_act_decoder.sv
// Actuator decoder/sequencer for the photon state FSM: qualifies a stable state
// code, drives the six actuator lines, holds each pattern and falls back to SAFE on silence.
module photon_act_decoder #(
   parameter int STABLE_CYCLES = 3,
   parameter int HOLD_CYCLES   = 4,
   parameter int WDOG_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [2:0] state_in,
   output logic [5:0] act,
   output logic [2:0] state_out,
   output logic       fault
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int WW = $clog2(WDOG_CYCLES + 1);

   localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);
   localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYCLES);
   localparam logic [WW-1:0] WDOG_LAST  = WW'(WDOG_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      QUAL,
      HOLD,
      RUN,
      SAFE
   } state_t;

   state_t          r_state;
   logic [2:0]      r_cand;
   logic [CW-1:0]   r_cnt;
   logic [HW-1:0]   r_holdCnt;
   logic [WW-1:0]   r_wdogCnt;
   logic [5:0]      r_act;
   logic [2:0]      r_stateOut;
   logic            r_fault;

   state_t          w_nState;
   logic [2:0]      w_nCand;
   logic [CW-1:0]   w_nCnt;
   logic [HW-1:0]   w_nHoldCnt;
   logic [WW-1:0]   w_nWdogCnt;
   logic [5:0]      w_nAct;
   logic [2:0]      w_nStateOut;
   logic            w_nFault;

   logic            w_beat;
   logic [CW-1:0]   w_cntPlus;
   logic            w_start;
   logic            w_apply;
   logic [2:0]      w_applyCode;

   function automatic logic [5:0] decodeAct(input logic [2:0] code);
      logic [5:0] pattern;
      case (code)
         3'd1:    pattern = 6'b110001;
         3'd2:    pattern = 6'b000010;
         3'd3:    pattern = 6'b111011;
         3'd4:    pattern = 6'b000100;
         3'd5:    pattern = 6'b111001;
         3'd6:    pattern = 6'b000010;
         3'd7:    pattern = 6'b111011;
         default: pattern = 6'b000000;
      endcase
      return pattern;
   endfunction

   // Gating with rst keeps a beat from being accepted while reset is asserted.
   assign in_ready  = !rst && (r_state != HOLD);
   assign w_beat    = in_valid && in_ready;
   assign w_cntPlus = (r_cnt == STABLE_MAX) ? r_cnt : r_cnt + CW'(1);

   assign act       = r_act;
   assign state_out = r_stateOut;
   assign fault     = r_fault;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cand     <= '0;
         r_cnt      <= '0;
         r_holdCnt  <= '0;
         r_wdogCnt  <= '0;
         r_act      <= '0;
         r_stateOut <= '0;
         r_fault    <= 1'b0;
      end else begin
         r_state    <= w_nState;
         r_cand     <= w_nCand;
         r_cnt      <= w_nCnt;
         r_holdCnt  <= w_nHoldCnt;
         r_wdogCnt  <= w_nWdogCnt;
         r_act      <= w_nAct;
         r_stateOut <= w_nStateOut;
         r_fault    <= w_nFault;
      end
   end

   always_comb begin
      w_nState    = r_state;
      w_nCand     = r_cand;
      w_nCnt      = r_cnt;
      w_nHoldCnt  = r_holdCnt;
      w_nWdogCnt  = r_wdogCnt;
      w_nAct      = r_act;
      w_nStateOut = r_stateOut;
      w_nFault    = r_fault;
      w_start     = 1'b0;
      w_apply     = 1'b0;
      w_applyCode = r_cand;

      case (r_state)
         IDLE: begin
            if (w_beat && (state_in != 3'd0)) begin
               w_start = 1'b1;
            end
         end
         QUAL: begin
            if (w_beat) begin
               if (state_in != r_cand) begin
                  w_start = 1'b1;
               end else if (w_cntPlus == STABLE_MAX) begin
                  w_apply = 1'b1;
               end else begin
                  w_nCnt = w_cntPlus;
               end
            end
         end
         HOLD: begin
            if (r_holdCnt <= HW'(1)) begin
               w_nHoldCnt = '0;
               w_nWdogCnt = '0;
               w_nState   = (r_stateOut == 3'd0) ? IDLE : RUN;
            end else begin
               w_nHoldCnt = r_holdCnt - HW'(1);
            end
         end
         RUN: begin
            if (w_beat) begin
               if (state_in == r_stateOut) begin
                  w_nWdogCnt = '0;
               end else begin
                  w_start = 1'b1;
               end
            end else if (r_wdogCnt >= WDOG_LAST) begin
               w_nWdogCnt  = '0;
               w_nAct      = '0;
               w_nStateOut = '0;
               w_nFault    = 1'b1;
               w_nState    = SAFE;
            end else begin
               w_nWdogCnt = r_wdogCnt + WW'(1);
            end
         end
         SAFE: begin
            if (w_beat && (state_in == 3'd0)) begin
               w_nFault = 1'b0;
               w_nCnt   = '0;
               w_nState = IDLE;
            end
         end
         default: begin
            w_nState = IDLE;
         end
      endcase

      // A fresh candidate counts as its first stable beat, so a threshold of one applies at once.
      if (w_start) begin
         w_nCand     = state_in;
         w_applyCode = state_in;
         if (STABLE_CYCLES == 1) begin
            w_apply = 1'b1;
         end else begin
            w_nCnt   = CW'(1);
            w_nState = QUAL;
         end
      end

      if (w_apply) begin
         w_nAct      = decodeAct(w_applyCode);
         w_nStateOut = w_applyCode;
         w_nHoldCnt  = HOLD_MAX;
         w_nCnt      = '0;
         w_nState    = HOLD;
      end
   end

endmodule

// File: doc/photon_act_decoder.md
# photon_act_decoder

Registered actuator decoder and sequencer on the output side of the photon state FSM. It accepts the 3-bit photon state code over a valid/ready stream and requires the code to be stable for a set number of beats before applying it. It then decodes the code into the six actuator drive lines, holds each applied pattern for a minimum time, and forces a safe all-off state with a fault flag if the state stream goes silent.

## Interface
Parameters:
- STABLE_CYCLES, 3: consecutive accepted beats with an identical code required before the code is applied; at least 1.
- HOLD_CYCLES, 4: minimum number of cycles an applied pattern is held with in_ready low; at least 1.
- WDOG_CYCLES, 16: idle cycles allowed in RUN before SAFE is entered; at least 2.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  state_in carries a code this cycle.
- in_ready  output  1  decoder accepts a beat this cycle.
- state_in  input  3  photon state code {q2,q1,q0}.
- act  output  6  actuator drive {A6,A5,A4,A3,A2,A1}; registered.
- state_out  output  3  currently applied code; registered.
- fault  output  1  watchdog fault, sticky until recovery.

## Operation
- A beat is accepted when in_valid and in_ready are both high.
- Decode table, code to act {A6..A1}: 0→000000, 1→110001, 2→000010, 3→111011, 4→000100, 5→111001, 6→000010, 7→111011.
- FSM states: IDLE, QUAL, HOLD, RUN, SAFE.
- IDLE: in_ready=1, act=0, applied code 0.
  - A beat with code 0 is ignored.
  - A beat with a nonzero code loads the candidate, sets cnt=1 and moves to QUAL.
- QUAL: in_ready=1; act and state_out keep the previous applied values.
  - A beat equal to the candidate increments cnt.
  - A beat with a different code reloads the candidate and sets cnt=1.
  - A cycle with no beat leaves cnt unchanged.
  - When a beat brings cnt to STABLE_CYCLES: act←decode(candidate), state_out←candidate, hold counter←HOLD_CYCLES, go to HOLD.
  - With STABLE_CYCLES=1, the beat that would set cnt=1 applies the code immediately, from IDLE or RUN.
- HOLD: in_ready=0. The hold counter decrements each cycle. At 0, go to IDLE if the applied code is 0, otherwise to RUN.
- RUN: in_ready=1.
  - A beat equal to the applied code reloads the watchdog.
  - A beat with a different code (including 0) starts QUAL as from IDLE.
  - The watchdog counts cycles without a beat. At WDOG_CYCLES, go to SAFE.
- SAFE: act=0, state_out=0, fault=1, in_ready=1.
  - Only an accepted code-0 beat recovers: fault is cleared and the FSM goes to IDLE.
  - Beats with other codes are accepted and discarded.
- The watchdog runs only in RUN. QUAL entered from RUN has no watchdog.
- Reset, at any time including mid-QUAL or mid-HOLD: FSM=IDLE, act=0, state_out=0, fault=0, cnt=0, all counters cleared.
  - in_ready reads 0 during the reset cycle and 1 from the first cycle after rst deasserts.

## Timing
- Every output is a flop, except in_ready, which is decoded from the registered FSM state.
- Apply latency: the beat completing qualification at edge t makes act and state_out valid from cycle t+1.
- Defaults, back-to-back beats from cycle 0: act changes in cycle 3, and in_ready is low in cycles 3–6.
- HOLD lasts exactly HOLD_CYCLES cycles, then in_ready rises.
- Watchdog: with the last RUN beat at cycle t, SAFE and fault=1 are visible at cycle t+WDOG_CYCLES+1, and act=0 in the same cycle.
- Counter widths are clog2(parameter+1). Counters saturate and never wrap.
- If rst and in_valid are high together, rst wins and the beat is not accepted.

## Test plan
- Reset then 3 back-to-back beats of code 5 → act=111001 and state_out=5 at cycle 3; in_ready=0 for cycles 3–6, then 1.
- Beats 3,3,1,1,1 → the candidate reloads on the first 1; act=110001 only after the third 1; act=0 before that.
- Apply code 2, then beats 3,3 with gaps of 5 idle cycles between them → act stays 000010, and the QUAL cnt holds across the gaps.
- Apply code 4, then no beats → fault=1, act=0 and state_out=0 exactly 17 cycles after the last beat; then a code-7 beat → still SAFE; then a code-0 beat → fault=0, IDLE.
- Apply code 3, then 3 beats of code 0 → act=000000, HOLD for 4 cycles, then IDLE; no fault after 40 idle cycles.
- Assert rst during HOLD of code 1 → the next cycle shows act=0, state_out=0, fault=0; after deassert, in_ready=1 and IDLE behaviour.
